counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 28 ++
 rtl/counter_ctrl.sv | 116 +++++++++++
 tb/tb_counter_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Control bus between the counter sequencer and its surroundings: button
// inputs, target/current count in, counter controls and status out.
interface counter_ctrl_if #(
    parameter int NUM_CNT_BITS = 8
);
    logic                    start_btn;
    logic                    stop_btn;
    logic                    clear_btn;
    logic [NUM_CNT_BITS-1:0] target;
    logic [NUM_CNT_BITS-1:0] count_in;
    logic                    count_enable;
    logic                    clear;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic                    done;
    logic [1:0]              state_out;

    // Drives buttons/target/count and observes the controls (testbench side).
    modport master (
        output start_btn, stop_btn, clear_btn, target, count_in,
        input  count_enable, clear, rollover_val, done, state_out
    );

    // The sequencer itself.
    modport slave (
        input  start_btn, stop_btn, clear_btn, target, count_in,
        output count_enable, clear, rollover_val, done, state_out
    );
endinterface

// File: rtl/counter_ctrl.sv
// Start/stop/clear sequencer for an external up-counter. Button rising edges
// move a four-state FSM; the counter is enabled in RUN until it reaches the
// latched target, after which a one-cycle done pulse is issued.
module counter_ctrl #(
    parameter int NUM_CNT_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] rollover_q, rollover_d;
    logic                    done_q, done_d;
    logic                    clear_q, clear_d;
    logic                    start_prev_q, stop_prev_q, clear_prev_q;

    logic start_edge, stop_edge, clear_edge;
    logic at_target;

    assign start_edge = bus.start_btn & ~start_prev_q;
    assign stop_edge  = bus.stop_btn  & ~stop_prev_q;
    assign clear_edge = bus.clear_btn & ~clear_prev_q;
    assign at_target  = (bus.count_in == rollover_q);

    // Button history, used to turn the level inputs into single-cycle events.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            start_prev_q <= bus.start_btn;
            stop_prev_q  <= bus.stop_btn;
            clear_prev_q <= bus.clear_btn;
        end
    end

    // FSM state, latched target and the registered clear/done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rollover_q <= '1;
            done_q     <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rollover_q <= rollover_d;
            done_q     <= done_d;
            clear_q    <= clear_d;
        end
    end

    // Next-state decode; clear beats stop beats start.
    // NOTE: every output of this block gets a default first, otherwise paths
    // that do not assign it would infer a latch.
    always_comb begin
        state_d    = state_q;
        rollover_d = rollover_q;
        done_d     = 1'b0;
        clear_d    = 1'b0;

        if (clear_edge) begin
            state_d = IDLE;
            clear_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d    = RUN;
                        rollover_d = bus.target;
                    end
                end
                RUN: begin
                    if (stop_edge) begin
                        state_d = PAUSE;
                    // While the counter is still being cleared, count_in holds
                    // the stale value from the previous run and must not end it.
                    end else if (at_target && !clear_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                PAUSE: begin
                    if (start_edge) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (start_edge) begin
                        state_d    = RUN;
                        rollover_d = bus.target;
                        clear_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Enable is combinational so the counter stops exactly on the target;
    // it is gated by rst because the state register only clears at the edge.
    assign bus.count_enable = ~rst && (state_q == RUN) && !at_target;
    assign bus.clear        = clear_q;
    assign bus.rollover_val = rollover_q;
    assign bus.done         = done_q;
    assign bus.state_out    = state_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural model of the counter
// being sequenced (synchronous clear, then enable-driven increment).
module tb_counter_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] cnt;
    int           checks = 0;
    int           errors = 0;
    int           en_cycles;
    int           done_cycles;
    int           done_at;

    counter_ctrl_if #(.NUM_CNT_BITS(W)) bus ();

    counter_ctrl #(.NUM_CNT_BITS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External counter driven by the DUT controls.
    always @(posedge clk) begin
        if (rst)                   cnt <= '0;
        else if (bus.clear)        cnt <= '0;
        else if (bus.count_enable) cnt <= cnt + 1'b1;
    end
    assign bus.count_in = cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sample n cycles, tallying enable-high cycles and done pulses.
    task automatic watch(input int n);
        en_cycles   = 0;
        done_cycles = 0;
        done_at     = -1;
        for (int i = 0; i < n; i++) begin
            if (bus.count_enable) en_cycles++;
            if (bus.done) begin
                done_cycles++;
                done_at = int'(cnt);
            end
            step();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_btn = 1'b0;
        bus.stop_btn  = 1'b0;
        bus.clear_btn = 1'b0;
        bus.target    = '0;
        step(2);

        // Reset state
        check("rst_state", bus.state_out, 2'b00);
        check("rst_rollover", bus.rollover_val, 8'hFF);
        check("rst_done", bus.done, 0);
        check("rst_clear", bus.clear, 0);
        check("rst_en", bus.count_enable, 0);

        // A start edge coinciding with reset is ignored
        bus.target    = 8'd5;
        bus.start_btn = 1'b1;
        step();
        check("rst_over_start", bus.state_out, 2'b00);
        rst           = 1'b0;
        bus.start_btn = 1'b0;
        step();
        check("post_rst_idle", bus.state_out, 2'b00);

        // Target 5 from IDLE
        bus.target    = 8'd5;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("t5_state_run", bus.state_out, 2'b01);
        check("t5_rollover", bus.rollover_val, 5);
        watch(12);
        check("t5_en_cycles", en_cycles, 5);
        check("t5_done_pulses", done_cycles, 1);
        check("t5_done_at", done_at, 5);
        check("t5_state_done", bus.state_out, 2'b11);
        check("t5_cnt_final", cnt, 5);
        check("t5_en_final", bus.count_enable, 0);

        // Restart from DONE with a new target of 3
        bus.target    = 8'd3;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("t3_clear_pulse", bus.clear, 1);
        check("t3_rollover", bus.rollover_val, 3);
        check("t3_state_run", bus.state_out, 2'b01);
        step();
        check("t3_clear_low", bus.clear, 0);
        check("t3_cnt_cleared", cnt, 0);
        watch(10);
        check("t3_en_cycles", en_cycles, 3);
        check("t3_done_pulses", done_cycles, 1);
        check("t3_done_at", done_at, 3);
        check("t3_state_done", bus.state_out, 2'b11);

        // Clear to IDLE, then target 0
        bus.clear_btn = 1'b1;
        step();
        bus.clear_btn = 1'b0;
        check("clr_pulse", bus.clear, 1);
        check("clr_state_idle", bus.state_out, 2'b00);
        step();
        check("clr_cnt", cnt, 0);
        check("clr_pulse_end", bus.clear, 0);
        bus.target    = 8'd0;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("t0_state_run", bus.state_out, 2'b01);
        check("t0_rollover", bus.rollover_val, 0);
        watch(4);
        check("t0_en_never", en_cycles, 0);
        check("t0_done_pulses", done_cycles, 1);
        check("t0_state_done", bus.state_out, 2'b11);

        // Target 200, pause at 50, resume
        bus.target    = 8'd200;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("p_clear_pulse", bus.clear, 1);
        check("p_rollover", bus.rollover_val, 200);
        for (int i = 0; i < 100 && cnt != 8'd49; i++) step();
        check("p_reach_49", cnt, 49);
        bus.stop_btn = 1'b1;
        step();
        bus.stop_btn = 1'b0;
        check("p_state_pause", bus.state_out, 2'b10);
        check("p_cnt_50", cnt, 50);
        check("p_en_off", bus.count_enable, 0);
        step(3);
        check("p_cnt_held", cnt, 50);
        bus.stop_btn = 1'b1;
        step();
        bus.stop_btn = 1'b0;
        check("p_stop_ignored", bus.state_out, 2'b10);
        bus.target    = 8'd9;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("r_state_run", bus.state_out, 2'b01);
        check("r_rollover_kept", bus.rollover_val, 200);
        check("r_no_clear", bus.clear, 0);
        check("r_en_on", bus.count_enable, 1);
        step();
        check("r_cnt_51", cnt, 51);
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        check("r_start_ignored", bus.state_out, 2'b01);
        check("r_no_relatch", bus.rollover_val, 200);

        // Clear, stop and start together during RUN
        bus.clear_btn = 1'b1;
        bus.stop_btn  = 1'b1;
        bus.start_btn = 1'b1;
        step();
        bus.clear_btn = 1'b0;
        bus.stop_btn  = 1'b0;
        bus.start_btn = 1'b0;
        check("all_clear", bus.clear, 1);
        check("all_state_idle", bus.state_out, 2'b00);
        step();
        check("all_clear_end", bus.clear, 0);
        check("all_cnt", cnt, 0);

        // Reset mid-RUN at count 10
        bus.target    = 8'd200;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        for (int i = 0; i < 50 && cnt != 8'd10; i++) step();
        check("m_reach_10", cnt, 10);
        rst = 1'b1;
        #1;
        check("m_en_in_rst", bus.count_enable, 0);
        step();
        check("m_state_idle", bus.state_out, 2'b00);
        check("m_rollover_ff", bus.rollover_val, 8'hFF);
        check("m_done_low", bus.done, 0);
        check("m_en_low", bus.count_enable, 0);
        rst = 1'b0;
        watch(4);
        check("m_no_done", done_cycles, 0);
        check("m_still_idle", bus.state_out, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
